// File: rtl/pipeline_job_sequencer.sv
// pipeline_job_sequencer: runs one pipeline job (feed, drain, readout); define SEQ_STALL_COUNTER_EN to build the stall counter
module pipeline_job_sequencer #(
    parameter int ADDR_WIDTH = 9,
    parameter int FULLNESS_LIMIT = 20,
    parameter int DRAIN_CYCLES = 1024,
    parameter int READ_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   botCount,
    input  logic                  srcValid,
    output logic                  srcReady,
    input  logic [127:0]          srcBot,
    input  logic [5:0]            srcPermutations,
    output logic [127:0]          bot,
    output logic [ADDR_WIDTH-1:0] botIndex,
    output logic                  isBotValid,
    output logic [5:0]            validBotPermutations,
    input  logic [4:0]            fifoFullness,
    input  logic [37:0]           summedDataOut,
    input  logic [2:0]            pcoeffCountOut,
    output logic                  resultValid,
    output logic [ADDR_WIDTH-1:0] resultIndex,
    output logic [37:0]           resultData,
    output logic [2:0]            resultPcoeff,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           stallCycles
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam int QW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CW-1:0] MAX_JOB = CW'(2 ** ADDR_WIDTH);
    localparam logic [5:0] LIMIT = 6'(FULLNESS_LIMIT);
    localparam logic [QW-1:0] QUIET_LAST = QW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, FEED, DRAIN, READ, DONE} stateT;

    stateT state, nextState;
    logic [CW-1:0] jobSize, issued, readCnt, clampedCount;
    logic [QW-1:0] quiet;
    logic [ADDR_WIDTH-1:0] feedIndex;
    logic [READ_LATENCY-1:0] pipeValid;
    logic [ADDR_WIDTH-1:0] pipeIndex [READ_LATENCY];
    logic transfer, readIssue, lastResult, quietDone;

    assign clampedCount = botCount > MAX_JOB ? MAX_JOB : botCount;
    assign srcReady = state == FEED && {1'b0, fifoFullness} < LIMIT && issued < jobSize;
    assign transfer = srcReady && srcValid;
    assign readIssue = state == READ && readCnt < jobSize;
    assign lastResult = resultValid && {1'b0, resultIndex} == jobSize - CW'(1);
    assign quietDone = fifoFullness == '0 && quiet == QUIET_LAST;
    assign botIndex = state == READ ? readCnt[ADDR_WIDTH-1:0] : feedIndex;
    assign busy = state != IDLE;
    assign done = state == DONE;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // phase sequencing: feed until N issued, drain until a full quiet run, read until last result
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = clampedCount == '0 ? DONE : FEED;
            FEED:    if (transfer && issued == jobSize - CW'(1)) nextState = DRAIN;
            DRAIN:   if (quietDone) nextState = READ;
            READ:    if (lastResult) nextState = DONE;
            default: nextState = IDLE;
        endcase
    end

    // job latch, bot issue register, quiet-run and read-address counters
    always_ff @(posedge clk) begin
        if (rst) begin
            jobSize <= '0;
            issued <= '0;
            readCnt <= '0;
            quiet <= '0;
            feedIndex <= '0;
            bot <= '0;
            validBotPermutations <= '0;
            isBotValid <= 1'b0;
        end else begin
            isBotValid <= transfer;
            quiet <= state == DRAIN && fifoFullness == '0 ? quiet + QW'(1) : '0;
            if (state == IDLE && start) begin
                jobSize <= clampedCount;
                issued <= '0;
                readCnt <= '0;
            end
            if (transfer) begin
                bot <= srcBot;
                validBotPermutations <= srcPermutations;
                feedIndex <= issued[ADDR_WIDTH-1:0];
                issued <= issued + CW'(1);
            end
            if (readIssue) readCnt <= readCnt + CW'(1);
        end
    end

    // read-latency tracker and registered result port
    always_ff @(posedge clk) begin
        if (rst) begin
            pipeValid <= '0;
            for (int i = 0; i < READ_LATENCY; i++) pipeIndex[i] <= '0;
            resultValid <= 1'b0;
            resultIndex <= '0;
            resultData <= '0;
            resultPcoeff <= '0;
        end else begin
            pipeValid[0] <= readIssue;
            pipeIndex[0] <= readCnt[ADDR_WIDTH-1:0];
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipeValid[i] <= pipeValid[i-1];
                pipeIndex[i] <= pipeIndex[i-1];
            end
            resultValid <= pipeValid[READ_LATENCY-1];
            if (pipeValid[READ_LATENCY-1]) begin
                resultIndex <= pipeIndex[READ_LATENCY-1];
                resultData <= summedDataOut;
                resultPcoeff <= pcoeffCountOut;
            end
        end
    end

`ifdef SEQ_STALL_COUNTER_EN
    // saturating count of cycles a pending bot was held back by FIFO fullness
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && start)) stallCycles <= '0;
        else if (state == FEED && srcValid && issued < jobSize && {1'b0, fifoFullness} >= LIMIT && stallCycles != '1)
            stallCycles <= stallCycles + 32'd1;
    end
`else
    assign stallCycles = '0;
`endif
endmodule

// File: tb/tb_pipeline_job_sequencer.sv
// tb_pipeline_job_sequencer: scoreboard bench for pipeline_job_sequencer with a behavioural pipeline read model
module tb_pipeline_job_sequencer;
    localparam int AW = 9;
    localparam int D = 1024;
    localparam int L = 3;
`ifdef SEQ_STALL_COUNTER_EN
    localparam logic [31:0] EXP_STALL = 32'd10;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, srcValid = 1'b0, clearPtr = 1'b0;
    logic [AW:0] botCount = '0;
    logic [4:0] fifoFullness = '0;
    logic [127:0] srcBot, bot;
    logic [5:0] srcPermutations, validBotPermutations;
    logic [37:0] summedDataOut, resultData;
    logic [2:0] pcoeffCountOut, resultPcoeff;
    logic srcReady, isBotValid, resultValid, busy, done;
    logic [AW-1:0] botIndex, resultIndex;
    logic [31:0] stallCycles;
    logic [AW-1:0] h1 = '0, h2 = '0, h3 = '0;
    int salt = 0, srcPtr = 0, cyc = 0, passed = 0, total = 0;
    int resTotal = 0, firstBotCyc = 0, lastBotCyc = 0, firstResCyc = 0, lastResCyc = 0, doneCyc = 0;

    typedef struct {logic [AW-1:0] idx; logic [127:0] data; logic [5:0] perm;} botExpT;
    typedef struct {logic [AW-1:0] idx; logic [37:0] data; logic [2:0] pc;} resExpT;
    botExpT botQ[$];
    resExpT resQ[$];

    function automatic logic [127:0] mkBot(input int i, input int s);
        return {32'(s), 32'(i), ~32'(i), 32'(i) * 32'h9E3779B1};
    endfunction
    function automatic logic [5:0] mkPerm(input int i, input int s);
        return 6'(i * 7 + s);
    endfunction
    function automatic logic [37:0] mkData(input int i, input int s);
        return {6'(s), 32'(i) * 32'h01000193 + 32'(s)};
    endfunction
    function automatic logic [2:0] mkPc(input int i, input int s);
        return 3'(i) ^ 3'(s);
    endfunction

    assign srcBot = mkBot(srcPtr, salt);
    assign srcPermutations = mkPerm(srcPtr, salt);
    assign summedDataOut = mkData(int'(h3), salt);
    assign pcoeffCountOut = mkPc(int'(h3), salt);

    pipeline_job_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .botCount(botCount),
        .srcValid(srcValid), .srcReady(srcReady), .srcBot(srcBot), .srcPermutations(srcPermutations),
        .bot(bot), .botIndex(botIndex), .isBotValid(isBotValid), .validBotPermutations(validBotPermutations),
        .fifoFullness(fifoFullness), .summedDataOut(summedDataOut), .pcoeffCountOut(pcoeffCountOut),
        .resultValid(resultValid), .resultIndex(resultIndex), .resultData(resultData), .resultPcoeff(resultPcoeff),
        .busy(busy), .done(done), .stallCycles(stallCycles)
    );

    initial forever #5 clk = ~clk;

    // cycle count, source item pointer and a READ_LATENCY-deep collector read model
    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
        srcPtr <= clearPtr ? 0 : srcPtr + int'(srcValid && srcReady);
        h1 <= botIndex;
        h2 <= h1;
        h3 <= h2;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // monitor: pops expected bots/results whenever the DUT presents one
    initial begin
        botExpT be;
        resExpT re;
        forever begin
            @(negedge clk);
            if (isBotValid) begin
                if (botIndex == '0) firstBotCyc = cyc;
                lastBotCyc = cyc;
                if (botQ.size() == 0) check("bot_unexpected", 1, 0);
                else begin
                    be = botQ.pop_front();
                    check("bot_index", botIndex, be.idx);
                    check("bot_data", bot, be.data);
                    check("bot_perm", validBotPermutations, be.perm);
                end
            end
            if (resultValid) begin
                if (resultIndex == '0) firstResCyc = cyc;
                lastResCyc = cyc;
                resTotal++;
                if (resQ.size() == 0) check("result_unexpected", 1, 0);
                else begin
                    re = resQ.pop_front();
                    check("result_index", resultIndex, re.idx);
                    check("result_data", resultData, re.data);
                    check("result_pcoeff", resultPcoeff, re.pc);
                end
            end
        end
    end

    task automatic resetChecks(input string nm);
        check({nm, "_bot"}, bot, 0);
        check({nm, "_outs"}, {botIndex, validBotPermutations, isBotValid, resultValid, resultIndex,
                              resultData, resultPcoeff, busy, done, srcReady, stallCycles}, 0);
    endtask

    task automatic startJob(input int bc, input int s);
        int n;
        n = bc > 512 ? 512 : bc;
        @(negedge clk);
        salt = s;
        for (int i = 0; i < n; i++) begin
            botQ.push_back('{AW'(i), mkBot(i, s), mkPerm(i, s)});
            resQ.push_back('{AW'(i), mkData(i, s), mkPc(i, s)});
        end
        botCount = (AW + 1)'(bc);
        start = 1'b1;
        clearPtr = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clearPtr = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic finishJob(input string nm, input int n, input int budget, input logic [31:0] expStall);
        int k;
        k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({nm, "_done_seen"}, done, 1);
        doneCyc = cyc;
        if (n > 0) check({nm, "_done_timing"}, doneCyc, lastResCyc + 1);
        check({nm, "_bots_left"}, botQ.size(), 0);
        check({nm, "_results_left"}, resQ.size(), 0);
        check({nm, "_stall"}, stallCycles, expStall);
        @(negedge clk);
        check({nm, "_idle"}, {busy, done}, 0);
    endtask

    task automatic waitResult(input int idx, input string nm);
        int k;
        k = 0;
        while (!(resultValid && resultIndex == AW'(idx)) && k < 4000) begin
            @(negedge clk);
            k++;
        end
        check(nm, resultValid && resultIndex == AW'(idx), 1);
    endtask

    initial begin
        int k, r0;
        srcValid = 1'b1;
        repeat (3) @(negedge clk);
        resetChecks("por");
        rst = 1'b0;

        startJob(4, 11);
        finishJob("basic", 4, 3000, 0);
        check("basic_bot_burst", lastBotCyc - firstBotCyc, 3);
        check("basic_drain_gap", firstResCyc - lastBotCyc, D + L + 1);

        startJob(8, 22);
        fifoFullness = 5'd20;
        repeat (10) begin
            #1 check("stall_ready_low", srcReady, 0);
            @(negedge clk);
        end
        fifoFullness = 5'd0;
        finishJob("stall", 8, 3000, EXP_STALL);

        startJob(2, 33);
        k = 0;
        while (!(isBotValid && botIndex == AW'(1)) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("drain_last_bot_seen", isBotValid && botIndex == AW'(1), 1);
        repeat (D - 1) @(negedge clk);
        fifoFullness = 5'd1;
        @(negedge clk);
        fifoFullness = 5'd0;
        finishJob("drain", 2, 4000, 0);
        check("drain_quiet_run", firstResCyc - lastBotCyc, 2 * D + L + 1);

        startJob(0, 44);
        check("zero_done_pulse", done, 1);
        finishJob("zero", 0, 5, 0);

        r0 = resTotal;
        startJob(1023, 55);
        finishJob("clamp", 512, 5000, 0);
        check("clamp_result_count", resTotal - r0, 512);

        startJob(6, 66);
        waitResult(2, "rst_mid_read_reached");
        #1 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        resetChecks("mid_read");
        botQ.delete();
        resQ.delete();
        repeat (10) @(negedge clk);
        check("mid_read_stays_idle", busy, 0);
        startJob(3, 77);
        finishJob("after_rst", 3, 3000, 0);

        startJob(5, 88);
        botCount = (AW + 1)'(2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitResult(0, "restart_read_reached");
        botCount = (AW + 1)'(7);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finishJob("restart", 5, 3000, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
